// File: rtl/sort4_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sort4_ctrl
// Summary  : Loads four 4-bit elements, bubble-sorts them one compare-swap per
//            cycle, then drains them in order.
//            Optional macro SORT4_EARLY_EXIT_EN ends the sort after a pass
//            that performs no swap.
// Revision : 1.0 - initial release
// ============================================================================
module sort4_ctrl #(
  parameter logic DESCEND = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic [2:0] swap_count
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t     state, next_state;
  logic [3:0] mem [4];
  logic [1:0] wr_idx, rd_idx, cmp_idx, limit;
  logic [1:0] cmp_nxt;
  logic [3:0] elem_a, elem_b;
  logic       do_swap, pass_end, early_exit;

  assign cmp_nxt  = cmp_idx + 2'd1;
  assign elem_a   = mem[cmp_idx];
  assign elem_b   = mem[cmp_nxt];
  // Strict comparison keeps equal values in place, so the sort is stable.
  assign do_swap  = DESCEND ? (elem_a < elem_b) : (elem_a > elem_b);
  assign pass_end = (cmp_idx == limit - 2'd1);

`ifdef SORT4_EARLY_EXIT_EN
  logic swap_flag;
  assign early_exit = ~(swap_flag | do_swap);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      swap_flag <= 1'b0;
    end else if (state == S_LOAD) begin
      swap_flag <= 1'b0;
    end else if (state == S_SORT) begin
      swap_flag <= pass_end ? 1'b0 : (swap_flag | do_swap);
    end
  end
`else
  assign early_exit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_LOAD;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 4'd0;
    busy       = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && wr_idx == 2'd3) next_state = S_SORT;
      end
      S_SORT: begin
        busy = 1'b1;
        if (pass_end && (limit == 2'd1 || early_exit)) next_state = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_data  = mem[rd_idx];
        if (out_ready && rd_idx == 2'd3) next_state = S_LOAD;
      end
      default: next_state = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= 4'd0;
      wr_idx     <= 2'd0;
      rd_idx     <= 2'd0;
      cmp_idx    <= 2'd0;
      limit      <= 2'd3;
      swap_count <= 3'd0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            mem[wr_idx] <= in_data;
            wr_idx      <= wr_idx + 2'd1;
            if (wr_idx == 2'd3) begin
              swap_count <= 3'd0;
              cmp_idx    <= 2'd0;
              limit      <= 2'd3;
            end
          end
        end
        S_SORT: begin
          if (do_swap) begin
            mem[cmp_idx] <= elem_b;
            mem[cmp_nxt] <= elem_a;
            swap_count   <= swap_count + 3'd1;
          end
          if (pass_end) begin
            cmp_idx <= 2'd0;
            limit   <= limit - 2'd1;
          end else begin
            cmp_idx <= cmp_nxt;
          end
        end
        S_DRAIN: begin
          if (out_ready) rd_idx <= rd_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sort4_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sort4_ctrl
// Summary  : Directed self-checking bench for sort4_ctrl, ascending and
//            descending instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sort4_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, vld, ordy, sel;
  logic [3:0] dat;

  logic       in_valid_a, out_ready_a, in_ready_a, out_valid_a, busy_a;
  logic       in_valid_d, out_ready_d, in_ready_d, out_valid_d, busy_d;
  logic [3:0] out_data_a, out_data_d;
  logic [2:0] swap_a, swap_d;

  logic       in_ready_m, out_valid_m, busy_m;
  logic [3:0] out_data_m;
  logic [2:0] swap_m;

  // sel chooses which instance receives stimulus; the other sits idle.
  assign in_valid_a  = vld & ~sel;
  assign out_ready_a = ordy & ~sel;
  assign in_valid_d  = vld & sel;
  assign out_ready_d = ordy & sel;

  assign in_ready_m  = sel ? in_ready_d  : in_ready_a;
  assign out_valid_m = sel ? out_valid_d : out_valid_a;
  assign out_data_m  = sel ? out_data_d  : out_data_a;
  assign busy_m      = sel ? busy_d      : busy_a;
  assign swap_m      = sel ? swap_d      : swap_a;

  sort4_ctrl #(.DESCEND(1'b0)) u_asc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_data(dat),
    .in_ready(in_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
    .out_ready(out_ready_a), .busy(busy_a), .swap_count(swap_a)
  );

  sort4_ctrl #(.DESCEND(1'b1)) u_desc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d), .in_data(dat),
    .in_ready(in_ready_d), .out_valid(out_valid_d), .out_data(out_data_d),
    .out_ready(out_ready_d), .busy(busy_d), .swap_count(swap_d)
  );

`ifdef SORT4_EARLY_EXIT_EN
  localparam int SORTED_CYCLES  = 3;
  localparam int ONE_PASS_SWAPS = 5;
`else
  localparam int SORTED_CYCLES  = 6;
  localparam int ONE_PASS_SWAPS = 6;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, 8'(in_ready_m), 8'd1);
    chk({tag, "_out_valid"}, 8'(out_valid_m), 8'd0);
    chk({tag, "_out_data"}, 8'(out_data_m), 8'd0);
    chk({tag, "_busy"}, 8'(busy_m), 8'd0);
    chk({tag, "_swap_count"}, 8'(swap_m), 8'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [3:0] a, b, c, d, input logic hold);
    logic [3:0] v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      chk("in_ready_load", 8'(in_ready_m), 8'd1);
      vld = 1'b1;
      dat = v[i];
      step();
    end
    vld = hold;
  endtask

  task automatic wait_sort(input int exp_cycles, input logic [2:0] exp_sw);
    int n;
    n = 0;
    chk("busy_start", 8'(busy_m), 8'd1);
    chk("in_ready_sort", 8'(in_ready_m), 8'd0);
    chk("out_valid_sort", 8'(out_valid_m), 8'd0);
    chk("out_data_sort", 8'(out_data_m), 8'd0);
    while (busy_m && n < 20) begin
      n++;
      dat = dat ^ 4'h9;
      step();
    end
    chk("sort_cycles", 8'(n), 8'(exp_cycles));
    chk("out_valid_after_sort", 8'(out_valid_m), 8'd1);
    chk("swap_count", 8'(swap_m), 8'(exp_sw));
  endtask

  // pat is read MSB first, cycling every plen cycles.
  task automatic drain(input logic [3:0] a, b, c, d, input logic [6:0] pat,
                       input int plen, input logic [2:0] exp_sw);
    logic [3:0] e [4];
    int idx, k;
    e   = '{a, b, c, d};
    idx = 0;
    k   = 0;
    while (idx < 4 && k < 40) begin
      chk("out_valid_drain", 8'(out_valid_m), 8'd1);
      chk("out_data", 8'(out_data_m), 8'(e[idx]));
      ordy = pat[plen - 1 - (k % plen)];
      dat  = dat ^ 4'h9;
      step();
      if (ordy) idx++;
      k++;
    end
    ordy = 1'b0;
    chk("drain_transfers", 8'(idx), 8'd4);
    chk("in_ready_after_drain", 8'(in_ready_m), 8'd1);
    chk("out_valid_after_drain", 8'(out_valid_m), 8'd0);
    chk("out_data_after_drain", 8'(out_data_m), 8'd0);
    chk("swap_count_held", 8'(swap_m), 8'(exp_sw));
  endtask

  initial begin
    sel   = 1'b0;
    rst_n = 1'b0;
    vld   = 1'b0;
    ordy  = 1'b0;
    dat   = 4'd0;
    step();
    step();
    chk_idle("reset_asc");
    sel = 1'b1;
    chk_idle("reset_desc");
    sel   = 1'b0;
    rst_n = 1'b1;

    // Ascending, base latency and swap count.
    load4(4'd9, 4'd3, 4'd7, 4'd1, 1'b0);
    wait_sort(6, 3'd5);
    drain(4'd1, 4'd3, 4'd7, 4'd9, 7'b1111111, 7, 3'd5);

    // Already sorted: early exit shortens SORT when enabled.
    load4(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    wait_sort(SORTED_CYCLES, 3'd0);
    drain(4'd1, 4'd2, 4'd3, 4'd4, 7'b1111111, 7, 3'd0);

    // One swap in pass 1, none in pass 2.
    load4(4'd1, 4'd2, 4'd4, 4'd3, 1'b0);
    wait_sort(ONE_PASS_SWAPS, 3'd1);
    drain(4'd1, 4'd2, 4'd3, 4'd4, 7'b1001101, 7, 3'd1);

    // Descending instance, equal values stay unswapped.
    sel = 1'b1;
    load4(4'd5, 4'd5, 4'd2, 4'd8, 1'b0);
    wait_sort(6, 3'd3);
    drain(4'd8, 4'd5, 4'd5, 4'd2, 7'b1001101, 7, 3'd3);
    sel = 1'b0;

    // Reset during a partial load.
    vld = 1'b1; dat = 4'd4; step();
    dat = 4'd1; step();
    vld = 1'b0; rst_n = 1'b0; step();
    rst_n = 1'b1;
    chk_idle("reset_mid_load");

    // Reset two cycles into a sort.
    load4(4'd6, 4'd5, 4'd4, 4'd3, 1'b0);
    step();
    step();
    chk("swaps_before_reset", 8'(swap_m), 8'd2);
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    chk_idle("reset_mid_sort");
    step();
    chk("no_output_after_reset", 8'(out_valid_m), 8'd0);

    load4(4'd2, 4'd0, 4'd3, 4'd1, 1'b0);
    wait_sort(6, 3'd3);
    drain(4'd0, 4'd1, 4'd2, 4'd3, 7'b1111111, 7, 3'd3);

    // in_valid held high with changing data outside LOAD.
    load4(4'd8, 4'd6, 4'd4, 4'd2, 1'b1);
    wait_sort(6, 3'd6);
    drain(4'd2, 4'd4, 4'd6, 4'd8, 7'b1111111, 7, 3'd6);
    load4(4'd3, 4'd3, 4'd1, 4'd0, 1'b0);
    wait_sort(6, 3'd5);
    drain(4'd0, 4'd1, 4'd3, 4'd3, 7'b1111111, 7, 3'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sort4_ctrl.md
SORT4_CTRL -- requirements
Module: sort4_ctrl

Interface
REQ-001 Parameter DESCEND, default 0: 0 = ascending output order, 1 = descending.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  in_data valid.
REQ-005 in_data  input  4  unsigned element to load.
REQ-006 in_ready  output  1  block accepts an element this cycle.
REQ-007 out_valid  output  1  out_data valid.
REQ-008 out_data  output  4  sorted element.
REQ-009 out_ready  input  1  downstream accepts out_data.
REQ-010 busy  output  1  high in SORT state.
REQ-011 swap_count  output  3  unsigned count of swaps performed by the current/last sort.

Function
REQ-012 Three-state FSM, LOAD -> SORT -> DRAIN -> LOAD; state encoding free.
REQ-013 Storage: 4 x 4-bit entries mem[0..3], 2-bit write index, 2-bit read index, 2-bit compare index, 2-bit pass limit.
REQ-014 LOAD: in_ready=1; on in_valid&in_ready write in_data to mem[wr_idx], wr_idx+1; in_valid without transfer has no effect.
REQ-015 On 4th accepted element (wr_idx==3): next state SORT, wr_idx wraps to 0, swap_count cleared to 0, compare index 0, pass limit 3.
REQ-016 SORT: exactly one compare-swap per cycle on pair (mem[j], mem[j+1]); in_ready=0, out_valid=0, busy=1.
REQ-017 Swap condition: DESCEND=0 swap iff mem[j] > mem[j+1]; DESCEND=1 swap iff mem[j] < mem[j+1]; equal values never swap (stable).
REQ-018 Each swap increments swap_count by 1 (maximum 6, no overflow possible).
REQ-019 Pass sequencing: j runs 0..limit-1; at j==limit-1, j returns to 0 and limit decrements; pass with limit 1 completing ends SORT -> DRAIN. Base total: 6 SORT cycles (3+2+1).
REQ-020 Latency: 4th accept at edge T -> out_valid high from cycle after edge T+6 (base build).
REQ-021 DRAIN: out_valid=1, out_data=mem[rd_idx]; on out_valid&out_ready rd_idx+1; out_ready low holds out_data stable.
REQ-022 4th drained element (rd_idx==3 transferred): rd_idx wraps to 0, next state LOAD; in_ready rises next cycle (no same-cycle load).
REQ-023 out_data SHALL be 0 whenever out_valid=0.
REQ-024 swap_count holds its value through DRAIN and subsequent LOAD until REQ-015 clears it.
REQ-025 in_data/in_valid ignored outside LOAD; out_ready ignored outside DRAIN.

Reset
REQ-026 rst_n low at rising edge: state LOAD, all indices 0, mem all 0, swap_count 0, pass limit 3, early-exit flag clear.
REQ-027 Reset outputs: in_ready=1, out_valid=0, out_data=0, busy=0, swap_count=0.
REQ-028 Reset mid-LOAD, mid-SORT or mid-DRAIN discards all partial data; no element output after reset until 4 new elements loaded.

Configuration
REQ-029 Macro SORT4_EARLY_EXIT_EN defined: per-pass swap flag, cleared at pass start; a pass completing with zero swaps ends SORT -> DRAIN immediately (already-sorted input: 3 SORT cycles).
REQ-030 Macro SORT4_EARLY_EXIT_EN undefined: always exactly 6 SORT cycles regardless of data; no swap flag logic present.
REQ-031 Sorted result and swap_count identical in both builds for any input.

Verification
REQ-032 Load 9,3,7,1 (DESCEND=0) -> drained 1,3,7,9; swap_count=5; out_valid 6 cycles after 4th accept (base).
REQ-033 Load 1,2,3,4 with SORT4_EARLY_EXIT_EN -> drained 1,2,3,4, swap_count=0, busy high exactly 3 cycles; without macro busy high 6 cycles.
REQ-034 DESCEND=1, load 5,5,2,8 -> drained 8,5,5,2; swap_count=3; equal 5s not swapped.
REQ-035 Drain with out_ready toggling 1,0,0,1,1,0,1 -> each element held while stalled, exactly 4 transfers, in_ready=1 on cycle after last.
REQ-036 Load 4,1, assert rst_n=0 one cycle mid-SORT of a later batch -> outputs per REQ-027; next load 2,0,3,1 drains 0,1,2,3.
REQ-037 in_valid held high continuously during SORT/DRAIN with changing in_data -> no extra elements captured; next batch starts with first beat after in_ready returns.
